// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the instruction sequencer slice:
//   - seq_state_t : sequencer FSM states (IDLE, FETCH, ISSUE, WAIT, HALT)
//   - SEQ_ADDR_W  : default instruction memory address width
//   - SEQ_DATA_W  : default instruction word width
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    localparam int SEQ_ADDR_W = 5;
    localparam int SEQ_DATA_W = 16;

endpackage

// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
// Bundles the sequencer's memory read port and processor issue handshake.
//   mem_addr : sequencer -> memory, instruction address
//   mem_q    : memory -> sequencer, read data (MEM_LAT cycles after mem_addr)
//   DIN      : sequencer -> processor, registered instruction word
//   run      : sequencer -> processor, one-cycle issue strobe
//   done     : processor -> sequencer, instruction completion
// Modports: master (sequencer side), slave (memory/processor side).
// -----------------------------------------------------------------------------
interface instr_sequencer_if
    import seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int DATA_W = SEQ_DATA_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] DIN;
    logic              run;
    logic              done;

    modport master (
        output mem_addr,
        output DIN,
        output run,
        input  mem_q,
        input  done
    );

    modport slave (
        input  mem_addr,
        input  DIN,
        input  run,
        output mem_q,
        output done
    );

endinterface

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Counts cycles while enabled; timeout is high during the WDT_CYCLES-th
// enabled cycle since the last clear.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count at zero
//   enable     : count this cycle
//   timeout    : limit reached in the current enabled cycle
// Instantiated by instr_sequencer only when SEQ_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module seq_watchdog #(
    parameter int WDT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = (WDT_CYCLES < 2) ? 1 : $clog2(WDT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of enabled cycles already completed.
    assign timeout = enable && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !timeout) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Reads instruction words from a synchronous memory, presents each on DIN,
// pulses run, waits for done, then advances. Halts after PROG_LEN words.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : begin a run from address 0 (honoured in IDLE/HALT only)
//   bus         : memory read port + processor handshake (master modport)
//   busy        : high in FETCH, ISSUE, WAIT
//   halted      : high in HALT
//   instr_count : instructions completed in the current run
//   wdt_err     : watchdog timeout flag
// Optional feature: define SEQ_WATCHDOG_EN to enable the WAIT watchdog
// (WDT_CYCLES); otherwise wdt_err is constant 0.
// -----------------------------------------------------------------------------
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W     = SEQ_ADDR_W,
    parameter int DATA_W     = SEQ_DATA_W,
    parameter int PROG_LEN   = 32,
    parameter int MEM_LAT    = 1,
    parameter int WDT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_sequencer_if.master bus,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W:0]   instr_count,
    output logic              wdt_err
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LAT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    seq_state_t       state, next_state;
    logic [LAT_W-1:0] lat_cnt;
    logic             timeout;
    logic             fetch_last;

    // FETCH lasts MEM_LAT+1 cycles: lat_cnt runs 0..MEM_LAT.
    assign fetch_last = (lat_cnt == LAT_LAST);

`ifdef SEQ_WATCHDOG_EN
    // Count is cleared during ISSUE so it starts at zero on WAIT entry.
    seq_watchdog #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ISSUE),
        .enable  (state == WAIT),
        .timeout (timeout)
    );
`else
    logic unused_wdt_cycles;
    assign unused_wdt_cycles = (WDT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: if (fetch_last) next_state = ISSUE;
            ISSUE: next_state = WAIT;
            WAIT: begin
                // done takes priority over a coincident timeout
                if (bus.done) begin
                    next_state = (bus.mem_addr == LAST_ADDR) ? HALT : FETCH;
                end else if (timeout) begin
                    next_state = HALT;
                end
            end
            HALT:  if (start) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they align with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_addr <= '0;
            bus.DIN      <= '0;
            bus.run      <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            instr_count  <= '0;
            wdt_err      <= 1'b0;
            lat_cnt      <= '0;
        end else begin
            bus.run <= (next_state == ISSUE);
            busy    <= (next_state == FETCH) || (next_state == ISSUE) ||
                       (next_state == WAIT);
            halted  <= (next_state == HALT);
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        bus.mem_addr <= '0;
                        instr_count  <= '0;
                        lat_cnt      <= '0;
                        wdt_err      <= 1'b0;
                    end
                end
                FETCH: begin
                    if (fetch_last) begin
                        bus.DIN <= bus.mem_q;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.done) begin
                        instr_count <= instr_count + 1'b1;
                        lat_cnt     <= '0;
                        if (bus.mem_addr != LAST_ADDR) begin
                            bus.mem_addr <= bus.mem_addr + 1'b1;
                        end
                    end else if (timeout) begin
                        wdt_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
